hub75_frame_scheduler: RTL and testbench

Owns the single-port 512×64 frame BRAM behind the HUB75 row reader and shares it between the display reader and a host frame loader. The BRAM is split into two 256-word banks, front and back. The reader always sees the front bank. The host writes into the back bank through a 4-entry write FIFO, and the banks swap only at a frame boundary after the host commits. The block sits between the row-reader BRAM port and the physical BRAM.

---
 rtl/hub75_pkg.sv | 11 +
 rtl/hub75_write_fifo.sv | 36 +++
 rtl/hub75_frame_scheduler.sv | 85 ++++++++
 tb/tb_hub75_frame_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and types for the HUB75 frame scheduler
package hub75_pkg;
  localparam int BANK_WORDS = 256;
  localparam int WORD_W = 64;
  localparam logic [4:0] LINE_LAST = 5'd31;
  typedef struct packed {
    logic [$clog2(BANK_WORDS)-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_entry_t;
  typedef enum logic {S_IDLE, S_PENDING} bank_state_e;
endpackage

// File: rtl/hub75_write_fifo.sv
// hub75_write_fifo: synchronous host write FIFO with full/empty flags
module hub75_write_fifo
  import hub75_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wr_entry_t din_i,
  output wr_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, rp_q;
  wr_entry_t mem_q [DEPTH];
  // pointers carry an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i) rp_q <= rp_q + 1'b1;
    end
  end
  // storage needs no reset; the pointers define validity
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end
  assign dout_o = mem_q[rp_q[AW-1:0]];
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/hub75_frame_scheduler.sv
// hub75_frame_scheduler: double-buffered frame BRAM arbiter with frame-boundary bank swap
module hub75_frame_scheduler
  import hub75_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [63:0]       rd_data,
  input  logic [4:0]        line,
  input  logic              line_next,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_addr,
  input  logic [63:0]       wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic              swap_done,
  output logic              front_bank,
  output logic [FCNT_W-1:0] frame_count,
  output logic [8:0]        bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [63:0]       bram_wrdata,
  input  logic [63:0]       bram_rddata
);
  wr_entry_t head;
  logic full, empty, push, pop, boundary, swap;
  bank_state_e state_q, state_d;
  logic front_bank_q, swap_done_q;
  logic [FCNT_W-1:0] frame_count_q;
  assign push = wr_valid && wr_ready;
  assign pop = !rst && !rd_en && !empty;
  assign boundary = line_next && line == LINE_LAST;
  assign swap = boundary && state_q == S_PENDING && empty;
  assign wr_ready = !rst && !full && !commit_pending;
  assign rd_data = bram_rddata;
  hub75_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .din_i('{addr: wr_addr, data: wr_data}),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  // commit state register
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IDLE : state_d;
  end
  // a commit arms the swap; a qualifying boundary fires it, repeat commits are ignored
  always_comb begin
    state_d = state_q == S_IDLE ? (commit ? S_PENDING : S_IDLE) : (swap ? S_IDLE : S_PENDING);
  end
  // commit state outputs
  always_comb begin
    commit_pending = state_q == S_PENDING;
  end
  // bank select, swap pulse and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank_q <= 1'b0;
      swap_done_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      front_bank_q <= front_bank_q ^ swap;
      swap_done_q <= swap;
      frame_count_q <= frame_count_q + FCNT_W'(boundary);
    end
  end
  assign front_bank = front_bank_q;
  assign swap_done = swap_done_q;
  assign frame_count = frame_count_q;
  // reader owns the port whenever it asks; queued writes fill idle cycles into the back bank
  always_comb begin
    bram_en = rd_en || pop;
    bram_we = pop;
    bram_addr = rd_en ? {front_bank_q, rd_addr} : {~front_bank_q, head.addr};
    bram_wrdata = head.data;
  end
endmodule

// File: tb/tb_hub75_frame_scheduler.sv
// tb_hub75_frame_scheduler: directed plus randomized check against a queue-based reference model
module tb_hub75_frame_scheduler;
  logic clk = 0, rst = 1, rd_en = 0, line_next = 0, wr_valid = 0, commit = 0;
  logic [7:0] rd_addr = 0, wr_addr = 0;
  logic [4:0] line = 0;
  logic [63:0] wr_data = 0, rd_data, bram_wrdata, bram_rddata;
  logic wr_ready, commit_pending, swap_done, front_bank, bram_en, bram_we;
  logic [15:0] frame_count;
  logic [8:0] bram_addr;
  int errors = 0, checks = 0;

  hub75_frame_scheduler dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .line(line), .line_next(line_next), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .swap_done(swap_done), .front_bank(front_bank), .frame_count(frame_count),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  always #5 clk = ~clk;

  logic [63:0] bmem [512];
  logic [63:0] m_mem [512];
  initial for (int i = 0; i < 512; i++) begin bmem[i] = 0; m_mem[i] = 0; end
  always @(posedge clk) if (bram_en) begin
    if (bram_we) bmem[bram_addr] <= bram_wrdata;
    else bram_rddata <= bmem[bram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [7:0] a; logic [63:0] d;} ent_t;
  ent_t q[$];
  bit m_live = 0, m_pend = 0, m_fb = 0, m_swapd = 0, m_rdv = 0, m_e0, m_bnd, m_sw, m_push;
  logic [15:0] m_fc = 0;
  logic [63:0] m_rd;

  always @(negedge clk) begin
    if (m_rdv) chk("rd_data", rd_data, m_rd);
    m_rdv = 0;
    if (rst) begin
      chk("wr_ready_rst", wr_ready, 0);
      q.delete();
      m_pend = 0; m_fb = 0; m_fc = 0; m_swapd = 0; m_live = 1;
    end else if (m_live) begin
      chk("front_bank", front_bank, m_fb);
      chk("commit_pending", commit_pending, m_pend);
      chk("swap_done", swap_done, m_swapd);
      chk("frame_count", frame_count, m_fc);
      chk("wr_ready", wr_ready, q.size() < 4 && !m_pend);
      m_e0 = q.size() == 0;
      m_push = wr_valid && q.size() < 4 && !m_pend;
      m_bnd = line_next && line == 5'd31;
      if (rd_en) begin
        chk("rd_en_en", bram_en, 1);
        chk("rd_en_we", bram_we, 0);
        chk("rd_addr", bram_addr, {m_fb, rd_addr});
        m_rd = m_mem[{m_fb, rd_addr}];
        m_rdv = 1;
      end else if (!m_e0) begin
        chk("wr_en", bram_en, 1);
        chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, {~m_fb, q[0].a});
        chk("wr_data", bram_wrdata, q[0].d);
        m_mem[{~m_fb, q[0].a}] = q[0].d;
        void'(q.pop_front());
      end else begin
        chk("idle_en", bram_en, 0);
        chk("idle_we", bram_we, 0);
      end
      if (m_push) q.push_back('{wr_addr, wr_data});
      m_sw = m_bnd && m_pend && m_e0;
      if (m_bnd) m_fc++;
      if (m_sw) begin m_fb = !m_fb; m_pend = 0; end
      else if (commit) m_pend = 1;
      m_swapd = m_sw;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base_a, input logic [63:0] base_d);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1; wr_addr = 8'(base_a + i); wr_data = base_d + 64'(i);
      step;
    end
    wr_valid = 0;
  endtask

  task automatic boundary;
    line = 31; line_next = 1;
    step;
    line = 0; line_next = 0;
  endtask

  initial begin
    step; step;
    rst = 0;
    @(negedge clk);
    chk("init_wr_ready", wr_ready, 1);
    chk("init_bram_en", bram_en, 0);
    chk("init_front", front_bank, 0);
    chk("init_fcnt", frame_count, 0);
    step;
    rd_en = 1;
    push_n(4, 0, 64'hA0);
    @(negedge clk);
    chk("full_wr_ready", wr_ready, 0);
    chk("busy_no_we", bram_we, 0);
    step;
    rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we", bram_we, 1);
      chk("drain_addr", bram_addr, 64'(256 + i));
      chk("drain_data", bram_wrdata, 64'(160 + i));
      step;
    end
    push_n(1, 5, 64'h55);
    rd_en = 1; rd_addr = 8'h10;
    @(negedge clk);
    chk("prio_addr", bram_addr, 64'h010);
    chk("prio_we", bram_we, 0);
    step;
    rd_en = 0;
    @(negedge clk);
    chk("late_we", bram_we, 1);
    chk("late_addr", bram_addr, 64'h105);
    step;
    commit = 1;
    step;
    commit = 0;
    @(negedge clk);
    chk("pend_up", commit_pending, 1);
    boundary;
    @(negedge clk);
    chk("swap_front", front_bank, 1);
    chk("swap_pulse", swap_done, 1);
    chk("swap_clear", commit_pending, 0);
    chk("swap_fcnt", frame_count, 1);
    step;
    @(negedge clk);
    chk("swap_once", swap_done, 0);
    rd_en = 1; rd_addr = 3;
    @(negedge clk);
    chk("front_rd_addr", bram_addr, 64'h103);
    step;
    rd_en = 0;
    @(negedge clk);
    chk("front_rd_data", rd_data, 64'hA3);
    step;
    rd_en = 1;
    push_n(2, 8'h20, 64'hB0);
    commit = 1;
    step;
    commit = 0;
    boundary;
    @(negedge clk);
    chk("defer_front", front_bank, 1);
    chk("defer_pend", commit_pending, 1);
    rd_en = 0;
    step; step;
    boundary;
    @(negedge clk);
    chk("late_swap_front", front_bank, 0);
    chk("late_swap_fcnt", frame_count, 3);
    commit = 1;
    step;
    commit = 0;
    boundary;
    rd_en = 1;
    push_n(3, 8'h40, 64'hC0);
    commit = 1;
    step;
    commit = 0;
    @(negedge clk);
    chk("pre_rst_pend", commit_pending, 1);
    chk("pre_rst_front", front_bank, 1);
    rst = 1;
    step;
    rst = 0; rd_en = 0;
    @(negedge clk);
    chk("rst_pend", commit_pending, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_wr_ready", wr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      @(negedge clk);
      chk("rst_no_we", bram_we, 0);
    end
    step;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      rd_en = $urandom_range(0, 1);
      rd_addr = 8'($urandom);
      wr_valid = $urandom_range(0, 2) != 0;
      wr_addr = 8'($urandom);
      wr_data = {$urandom, $urandom};
      commit = $urandom_range(0, 15) == 0;
      line_next = $urandom_range(0, 5) == 0;
      line = $urandom_range(0, 2) == 0 ? 5'd31 : 5'($urandom_range(0, 30));
      step;
    end
    rst = 0; rd_en = 0; wr_valid = 0; commit = 0; line_next = 0;
    step; step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
